mult_eight_seq: RTL and testbench

//  Sequencer that time-shares one add_eight (8-bit ripple adder) to compute an unsigned
//  8x8->16 product by shift-and-add, one adder pass per clock.

---
 rtl/mult_eight_seq.sv | 137 +++++++++++++
 tb/tb_mult_eight_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mult_eight_seq.sv
// Shift-and-add 8x8->16 unsigned multiplier sequencer time-sharing one 8-bit ripple adder.
// Optional macro MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.

module add_eight (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [8:0] w_c;

  assign w_c[0] = i_cin;

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_fa
      assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1]   = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end
  endgenerate

  assign o_cout = w_c[8];
endmodule

module mult_eight_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_m, r_ph, r_pl;
  logic [WIDTH-1:0]     w_m_nxt, w_ph_nxt, w_pl_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic [2*WIDTH-1:0]   r_product, w_product_nxt;

  logic [WIDTH-1:0]     w_addend, w_sum;
  logic                 w_cout;

  // Only add the multiplicand when the current multiplier bit is set.
  assign w_addend = r_pl[0] ? r_m : '0;

  add_eight u_add (
    .i_a   (r_ph),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

`ifdef MULT_EARLY_EXIT_EN
  logic [CNT_W:0]       w_rem;
  logic [2*WIDTH-1:0]   w_early;
  logic [WIDTH-1:0]     w_mask;

  // Bits PL[WIDTH-1-count:0] still hold unprocessed multiplier bits.
  assign w_mask  = {WIDTH{1'b1}} >> r_count;
  assign w_rem   = (CNT_W+1)'(WIDTH) - {1'b0, r_count};
  assign w_early = {r_ph, r_pl} >> w_rem;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_ph      <= '0;
      r_pl      <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_m       <= w_m_nxt;
      r_ph      <= w_ph_nxt;
      r_pl      <= w_pl_nxt;
      r_count   <= w_count_nxt;
      r_product <= w_product_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_m_nxt       = r_m;
    w_ph_nxt      = r_ph;
    w_pl_nxt      = r_pl;
    w_count_nxt   = r_count;
    w_product_nxt = r_product;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_m_nxt     = a;
          w_pl_nxt    = b;
          w_ph_nxt    = '0;
          w_count_nxt = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // {cout,sum,PL} >> 1: carry enters PH msb, sum lsb enters PL msb.
        w_ph_nxt    = {w_cout, w_sum[WIDTH-1:1]};
        w_pl_nxt    = {w_sum[0], r_pl[WIDTH-1:1]};
        w_count_nxt = r_count + CNT_W'(1);
        if (r_count == CNT_W'(WIDTH - 1)) begin
          w_product_nxt = {w_ph_nxt, w_pl_nxt};
          w_state_nxt   = S_DONE;
        end
`ifdef MULT_EARLY_EXIT_EN
        else if ((r_pl & w_mask) == '0) begin
          w_ph_nxt      = w_early[2*WIDTH-1:WIDTH];
          w_pl_nxt      = w_early[WIDTH-1:0];
          w_product_nxt = w_early;
          w_state_nxt   = S_DONE;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
endmodule

// File: tb/tb_mult_eight_seq.sv
// Randomized and directed bench for mult_eight_seq against an arithmetic reference model.
// Honours MULT_EARLY_EXIT_EN the same way the design does.

module tb_mult_eight_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_eight_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from accept (counted as 1) to the edge after which done is seen.
  function automatic int exp_lat(input logic [7:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    int len;
    len = 0;
    for (int i = 0; i < 8; i++) if (bv[i]) len = i + 1;
    return (len + 2 > 9) ? 9 : len + 2;
`else
    return 9;
`endif
  endfunction

  // Runs one operation from IDLE; reports what was observed, judges nothing.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic [15:0] prod,
                        output logic busy_acc, output logic d_after, output logic b_after);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    busy_acc = busy;
    a = 8'($urandom); b = 8'($urandom);
    lat = -1; prod = 16'hxxxx;
    for (int k = 1; k <= 30; k++) begin
      if (done) begin
        lat = k; prod = product;
        break;
      end
      tick();
    end
    tick();
    d_after = done;
    b_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; a = 8'd5; b = 8'd5;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
    reset = 1'b0; start = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [7:0]  ta [6] = '{8'd13, 8'hFF, 8'h00, 8'd9, 8'd9, 8'd9};
    logic [7:0]  tb_ [6] = '{8'd11, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h80};
    int lat; logic [15:0] prod; logic bacc, dafter, bafter;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb_[i], lat, prod, bacc, dafter, bafter);
      n_checks++; if (bacc !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy_run got %b want 1", i, bacc); end
      n_checks++; if (lat != exp_lat(tb_[i])) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat(tb_[i])); end
      n_checks++; if (prod !== 16'(ta[i]) * 16'(tb_[i])) begin n_fail++; $display("FAIL dir%0d_product got %h want %h", i, prod, 16'(ta[i]) * 16'(tb_[i])); end
      n_checks++; if (dafter !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got %b want 0", i, dafter); end
      n_checks++; if (bafter !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_after got %b want 0", i, bafter); end
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] prod; logic bacc, dafter, bafter;
    logic [7:0] ra, rb;
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom);
      rb = (i % 5 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      run_op(ra, rb, lat, prod, bacc, dafter, bafter);
      n_checks++; if (prod !== 16'(ra) * 16'(rb)) begin n_fail++; $display("FAIL rnd%0d_product a=%0d b=%0d got %h want %h", i, ra, rb, prod, 16'(ra) * 16'(rb)); end
      n_checks++; if (lat != exp_lat(rb)) begin n_fail++; $display("FAIL rnd%0d_latency b=%h got %0d want %0d", i, rb, lat, exp_lat(rb)); end
      n_checks++; if (dafter !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_done_pulse got %b want 0", i, dafter); end
    end
  endtask

  task automatic test_back_to_back();
    int nd, c1, c2; logic [15:0] p1, p2;
    nd = 0; c1 = -1; c2 = -1; p1 = 16'hxxxx; p2 = 16'hxxxx;
    a = 8'd3; b = 8'd4; start = 1'b1;
    tick();
    a = 8'd5; b = 8'd6;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        if (nd == 0) begin c1 = k; p1 = product; end
        else begin c2 = k; p2 = product; break; end
        nd++;
      end
      tick();
    end
    start = 1'b0;
    n_checks++; if (p1 !== 16'd12) begin n_fail++; $display("FAIL b2b_first_product got %h want %h", p1, 16'd12); end
    n_checks++; if (c1 != exp_lat(8'd4)) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", c1, exp_lat(8'd4)); end
    n_checks++; if (p2 !== 16'd30) begin n_fail++; $display("FAIL b2b_second_product got %h want %h", p2, 16'd30); end
    n_checks++; if (c2 != exp_lat(8'd4) + 1 + exp_lat(8'd6)) begin n_fail++; $display("FAIL b2b_second_time got %0d want %0d", c2, exp_lat(8'd4) + 1 + exp_lat(8'd6)); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int saw; int lat; logic [15:0] prod; logic bacc, dafter, bafter;
    a = 8'd200; b = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (product !== 16'h0000) begin n_fail++; $display("FAIL abort_product got %h want 0000", product); end
    saw = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) saw++;
      tick();
    end
    n_checks++; if (saw != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", saw); end
    run_op(8'd2, 8'd3, lat, prod, bacc, dafter, bafter);
    n_checks++; if (prod !== 16'd6) begin n_fail++; $display("FAIL abort_next_product got %h want %h", prod, 16'd6); end
    n_checks++; if (lat != exp_lat(8'd3)) begin n_fail++; $display("FAIL abort_next_latency got %0d want %0d", lat, exp_lat(8'd3)); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
